raman: RTL and testbench
========================

Name: raman

Overview:
- Accumulates repeated spectrometer scans point-by-point in an internal 12-bit FIFO ring.
- After MEASURES scans it averages the accumulated spectrum and integrates five band sums.
- It then drains the averaged spectrum on q for the downstream ratio/readout logic.
- It sits between the ADC sample stream and the ratio/host readout stage.

Parameters:
- POINTS, 2000, samples per scan (≤2048; also FIFO depth).
- MEASURES, 100, scans accumulated per batch.
- RECIP, 655, round(65536/MEASURES), used for averaging.
- BAND_W, 256, points per band; band n covers points [n*BAND_W, (n+1)*BAND_W).

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- data  in  12  sample input, one per clock during SCAN
- enable  in  1  scan trigger; falling edge starts a scan
- q  out  12  FIFO head (show-ahead, combinational from head entry)
- rdreq  out  1  FIFO pop strobe
- wrreq  out  1  FIFO push strobe
- cnt_point  out  11  point index during SCAN
- cnt_measure  out  17  accepted scans since reset, wraps mod 2^17
- cnt_save  out  4  completed batches, wraps mod 16
- cnt_div  out  11  point index during DIV
- cnt_ratio  out  11  point index during RATIO
- div_en  out  1  high throughout DIV
- ratio_en  out  1  high throughout RATIO
- ready  out  1  1-cycle pulse: sums valid
- ready_ratio  out  1  1-cycle pulse: batch drained
- switch  out  1  toggles once per completed batch
- sum1, sum2, sum3, sum5, sum6  out  12 each  band integrals of averaged spectrum (bands 1,2,3,5,6)

Behaviour:
- States: IDLE, SCAN, DIV, RATIO.
- Reset (reset_n=0 at an edge):
  - state=IDLE; FIFO emptied; all counters, sums, strobes, pulses and switch = 0; internal batch scan count = 0; enable history = 0.
  - Reset mid-operation aborts it; partial data is discarded.
- Trigger:
  - A falling edge is enable_d=1 and enable=0, where enable_d is enable registered on the previous cycle.
  - Only a falling edge seen in IDLE is accepted.
  - Falling edges during SCAN, DIV or RATIO are ignored and not counted.
- SCAN:
  - Entered the cycle after an accepted edge; lasts exactly POINTS cycles.
  - cnt_point = 0..POINTS-1; data is sampled every cycle; wrreq=1 every cycle.
  - First scan of a batch: rdreq=0; the pushed value is data.
  - Later scans: rdreq=1; the pushed value is min(q+data, 4095), a 13-bit add saturated to 12 bits.
  - At the last point: cnt_measure++ and the batch count is incremented.
  - If the batch count reaches MEASURES → DIV, else → IDLE.
- DIV:
  - Lasts POINTS cycles; div_en=1; cnt_div = 0..POINTS-1; rdreq=1, wrreq=1.
  - avg = (q*RECIP)>>16, truncated to 12 bits; avg is pushed back.
  - sum1..sum6 are cleared on DIV entry. If cnt_div is in band n (n in {1,2,3,5,6}), sum_n = min(sum_n+avg, 4095).
  - After the last point: ready=1 for one cycle; sums hold until the next DIV entry; → RATIO.
- RATIO:
  - Lasts POINTS cycles; ratio_en=1; cnt_ratio = 0..POINTS-1; rdreq=1, wrreq=0.
  - q carries the averaged point cnt_ratio each cycle.
  - After the last point: ready_ratio=1 for one cycle, cnt_save++, switch toggles, batch count=0, FIFO empty → IDLE.
- Counters outside their state hold their last value (cnt_point, cnt_div, cnt_ratio).
- Strobes rdreq and wrreq are 0 in IDLE.
- FIFO:
  - Internal ring, depth ≥ POINTS.
  - Simultaneous pop and push of the same entry is legal; pop takes the old head, push goes to the tail.
  - Never overflows: each state pushes at most what it pops, except the first scan, which fills an empty FIFO.
- A new trigger is accepted no earlier than the first IDLE cycle after RATIO.

Test Plan:
(POINTS=16, MEASURES=4, RECIP=16384, BAND_W=2 unless stated.)
- Reset: hold reset_n=0 for 3 clocks with enable toggling → every output 0, state IDLE; after release, no scan starts until an enable high→low.
- Single scan: enable 1→0, data=10 for 16 cycles → wrreq=1 and rdreq=0 for 16 cycles; cnt_point 0..15; cnt_measure=1; q=10 at the head.
- Accumulation: four scans of data=10 → during scans 2–4 rdreq=1 and q=10, 20, 30 respectively; then DIV with q=40, pushed avg=10.
  - After 16 DIV cycles, ready pulses once: sum1=sum2=sum3=sum5=sum6=20.
- Drain: following RATIO → ratio_en=1 for 16 cycles with q=10 and cnt_ratio 0..15.
  - Then ready_ratio pulses once; cnt_save=1, switch=1, FIFO empty.
  - A second batch ends with cnt_save=2 and switch=0.
- Saturation: MEASURES=2, data=4000 for both scans → pushed value 4095 (not 3904); avg=(4095*32768)>>16=2047.
- Ignored triggers / reset mid-scan:
  - An enable falling edge during DIV leaves cnt_measure unchanged.
  - reset_n=0 at cnt_point=7 → all outputs 0, FIFO empty; the next scan behaves as a first scan (rdreq=0).

Source files
------------

// File: rtl/raman.sv
// raman - repeated-scan spectrum accumulator with averaging and band sums.
//
// Accumulates MEASURES spectrometer scans point-by-point in an internal
// 12-bit ring FIFO, then averages the accumulated spectrum, integrates five
// band sums and finally drains the averaged spectrum on q for the
// downstream ratio/readout stage.
//
// Ports:
//   clock        system clock, all logic on the rising edge
//   reset_n      synchronous active-low reset
//   data         12-bit sample input, one per clock during SCAN
//   enable       scan trigger, a falling edge seen in IDLE starts a scan
//   q            FIFO head (show-ahead), 0 while the FIFO is empty
//   rdreq/wrreq  FIFO pop / push strobes
//   cnt_point    point index during SCAN
//   cnt_measure  accepted scans since reset (wraps)
//   cnt_save     completed batches (wraps)
//   cnt_div      point index during DIV
//   cnt_ratio    point index during RATIO
//   div_en       high throughout DIV
//   ratio_en     high throughout RATIO
//   ready        1-cycle pulse, band sums valid
//   ready_ratio  1-cycle pulse, batch drained
//   switch       toggles once per completed batch
//   sum1..sum6   saturated band integrals of the averaged spectrum

module raman #(
  parameter int POINTS   = 2000,
  parameter int MEASURES = 100,
  parameter int RECIP    = 655,
  parameter int BAND_W   = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] data,
  input  logic        enable,
  output logic [11:0] q,
  output logic        rdreq,
  output logic        wrreq,
  output logic [10:0] cnt_point,
  output logic [16:0] cnt_measure,
  output logic [3:0]  cnt_save,
  output logic [10:0] cnt_div,
  output logic [10:0] cnt_ratio,
  output logic        div_en,
  output logic        ratio_en,
  output logic        ready,
  output logic        ready_ratio,
  output logic        switch,
  output logic [11:0] sum1,
  output logic [11:0] sum2,
  output logic [11:0] sum3,
  output logic [11:0] sum5,
  output logic [11:0] sum6
);

  localparam int AW = (POINTS > 1) ? $clog2(POINTS) : 1;
  localparam int BW = $clog2(MEASURES + 1);
  localparam logic [10:0]   POINT_LAST = 11'(POINTS - 1);
  localparam logic [BW-1:0] BATCH_LAST = BW'(MEASURES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DIV, RATIO} state_t;

  state_t        state;
  state_t        next_state;
  logic          enable_d;
  logic          fall;
  logic [BW-1:0] batch_cnt;
  logic          first_scan;
  logic          scan_last;
  logic          div_last;
  logic          ratio_last;

  logic [11:0]   mem [POINTS];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   fifo_cnt;
  logic [11:0]   wdata;
  logic [11:0]   avg;

  function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[12] ? 12'hFFF : s[11:0];
  endfunction

  // Ring pointers wrap at POINTS so depth need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(POINTS - 1)) ? '0 : p + AW'(1);
  endfunction

  function automatic logic in_band(input logic [10:0] idx, input int n);
    return (int'(idx) >= n * BAND_W) && (int'(idx) < (n + 1) * BAND_W);
  endfunction

  assign fall       = enable_d & ~enable;
  assign first_scan = (batch_cnt == '0);
  assign scan_last  = (cnt_point == POINT_LAST);
  assign div_last   = (cnt_div == POINT_LAST);
  assign ratio_last = (cnt_ratio == POINT_LAST);

  // Show-ahead head; an empty FIFO presents 0 rather than stale contents.
  assign q   = (fifo_cnt == '0) ? 12'd0 : mem[head];
  assign avg = 12'((29'(q) * 29'(RECIP)) >> 16);

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fall) next_state = SCAN;
      SCAN:    if (scan_last) next_state = (batch_cnt == BATCH_LAST) ? DIV : IDLE;
      DIV:     if (div_last) next_state = RATIO;
      RATIO:   if (ratio_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State-decoded strobes
  always_comb begin
    rdreq    = 1'b0;
    wrreq    = 1'b0;
    div_en   = 1'b0;
    ratio_en = 1'b0;
    case (state)
      SCAN: begin
        wrreq = 1'b1;
        rdreq = ~first_scan;
      end
      DIV: begin
        rdreq  = 1'b1;
        wrreq  = 1'b1;
        div_en = 1'b1;
      end
      RATIO: begin
        rdreq    = 1'b1;
        ratio_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Value pushed to the tail: raw sample on the first scan, saturated
  // running sum on later scans, averaged point during DIV.
  always_comb begin
    wdata = 12'd0;
    case (state)
      SCAN:    wdata = first_scan ? data : sat_add(q, data);
      DIV:     wdata = avg;
      default: ;
    endcase
  end

  // Counters, band sums and completion pulses
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      enable_d    <= 1'b0;
      batch_cnt   <= '0;
      cnt_point   <= '0;
      cnt_measure <= '0;
      cnt_save    <= '0;
      cnt_div     <= '0;
      cnt_ratio   <= '0;
      ready       <= 1'b0;
      ready_ratio <= 1'b0;
      switch      <= 1'b0;
      sum1        <= '0;
      sum2        <= '0;
      sum3        <= '0;
      sum5        <= '0;
      sum6        <= '0;
    end else begin
      enable_d    <= enable;
      ready       <= 1'b0;
      ready_ratio <= 1'b0;
      case (state)
        IDLE: if (fall) cnt_point <= '0;
        SCAN: begin
          if (!scan_last) begin
            cnt_point <= cnt_point + 11'd1;
          end else begin
            cnt_measure <= cnt_measure + 17'd1;
            batch_cnt   <= batch_cnt + BW'(1);
            if (batch_cnt == BATCH_LAST) begin
              cnt_div <= '0;
              sum1    <= '0;
              sum2    <= '0;
              sum3    <= '0;
              sum5    <= '0;
              sum6    <= '0;
            end
          end
        end
        DIV: begin
          if (in_band(cnt_div, 1)) sum1 <= sat_add(sum1, avg);
          if (in_band(cnt_div, 2)) sum2 <= sat_add(sum2, avg);
          if (in_band(cnt_div, 3)) sum3 <= sat_add(sum3, avg);
          if (in_band(cnt_div, 5)) sum5 <= sat_add(sum5, avg);
          if (in_band(cnt_div, 6)) sum6 <= sat_add(sum6, avg);
          if (!div_last) begin
            cnt_div <= cnt_div + 11'd1;
          end else begin
            ready     <= 1'b1;
            cnt_ratio <= '0;
          end
        end
        RATIO: begin
          if (!ratio_last) begin
            cnt_ratio <= cnt_ratio + 11'd1;
          end else begin
            ready_ratio <= 1'b1;
            cnt_save    <= cnt_save + 4'd1;
            switch      <= ~switch;
            batch_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Ring pointers; a simultaneous pop and push leaves the fill level alone.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head     <= '0;
      tail     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (rdreq) head <= ptr_inc(head);
      if (wrreq) tail <= ptr_inc(tail);
      case ({wrreq, rdreq})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage is left unreset so it can map onto block RAM.
  always_ff @(posedge clock) begin
    if (reset_n && wrreq) mem[tail] <= wdata;
  end

endmodule

// File: tb/tb_raman.sv
// tb_raman - scoreboard bench for raman.
//
// Two instances share the clock: dut_a (MEASURES=4, RECIP=16384, BAND_W=2)
// and dut_b (MEASURES=2, RECIP=32768, BAND_W=4) for saturation. 'sel'
// routes enable to one instance and picks which outputs are observed.
// A software model of the accumulated spectrum predicts q during each scan
// and DIV; averaged points are queued during DIV and popped during RATIO.

module tb_raman;

  localparam int P = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        enable;
  logic        sel;
  logic [11:0] data;
  logic        en_a;
  logic        en_b;

  logic [11:0] a_q, b_q;
  logic        a_rdreq, b_rdreq, a_wrreq, b_wrreq;
  logic [10:0] a_cnt_point, b_cnt_point, a_cnt_div, b_cnt_div, a_cnt_ratio, b_cnt_ratio;
  logic [16:0] a_cnt_measure, b_cnt_measure;
  logic [3:0]  a_cnt_save, b_cnt_save;
  logic        a_div_en, b_div_en, a_ratio_en, b_ratio_en;
  logic        a_ready, b_ready, a_ready_ratio, b_ready_ratio, a_switch, b_switch;
  logic [11:0] a_sum1, a_sum2, a_sum3, a_sum5, a_sum6;
  logic [11:0] b_sum1, b_sum2, b_sum3, b_sum5, b_sum6;

  logic [11:0] o_q;
  logic        o_rdreq, o_wrreq;
  logic [10:0] o_cnt_point, o_cnt_div, o_cnt_ratio;
  logic [16:0] o_cnt_measure;
  logic [3:0]  o_cnt_save;
  logic        o_div_en, o_ratio_en, o_ready, o_ready_ratio, o_switch;
  logic [11:0] o_sum1, o_sum2, o_sum3, o_sum5, o_sum6;

  int checks;
  int failures;
  int acc [P];
  int batch;
  int measure;
  int save;
  int sw;
  int drain_q [$];

  // The idle instance sees enable held high so it never triggers.
  assign en_a = sel ? 1'b1 : enable;
  assign en_b = sel ? enable : 1'b1;

  raman #(.POINTS(P), .MEASURES(4), .RECIP(16384), .BAND_W(2)) dut_a (
    .clock(clock), .reset_n(reset_n), .data(data), .enable(en_a),
    .q(a_q), .rdreq(a_rdreq), .wrreq(a_wrreq),
    .cnt_point(a_cnt_point), .cnt_measure(a_cnt_measure), .cnt_save(a_cnt_save),
    .cnt_div(a_cnt_div), .cnt_ratio(a_cnt_ratio),
    .div_en(a_div_en), .ratio_en(a_ratio_en),
    .ready(a_ready), .ready_ratio(a_ready_ratio), .switch(a_switch),
    .sum1(a_sum1), .sum2(a_sum2), .sum3(a_sum3), .sum5(a_sum5), .sum6(a_sum6)
  );

  raman #(.POINTS(P), .MEASURES(2), .RECIP(32768), .BAND_W(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .data(data), .enable(en_b),
    .q(b_q), .rdreq(b_rdreq), .wrreq(b_wrreq),
    .cnt_point(b_cnt_point), .cnt_measure(b_cnt_measure), .cnt_save(b_cnt_save),
    .cnt_div(b_cnt_div), .cnt_ratio(b_cnt_ratio),
    .div_en(b_div_en), .ratio_en(b_ratio_en),
    .ready(b_ready), .ready_ratio(b_ready_ratio), .switch(b_switch),
    .sum1(b_sum1), .sum2(b_sum2), .sum3(b_sum3), .sum5(b_sum5), .sum6(b_sum6)
  );

  // Observed outputs of the selected instance
  always_comb begin
    if (sel) begin
      o_q = b_q; o_rdreq = b_rdreq; o_wrreq = b_wrreq;
      o_cnt_point = b_cnt_point; o_cnt_div = b_cnt_div; o_cnt_ratio = b_cnt_ratio;
      o_cnt_measure = b_cnt_measure; o_cnt_save = b_cnt_save;
      o_div_en = b_div_en; o_ratio_en = b_ratio_en;
      o_ready = b_ready; o_ready_ratio = b_ready_ratio; o_switch = b_switch;
      o_sum1 = b_sum1; o_sum2 = b_sum2; o_sum3 = b_sum3; o_sum5 = b_sum5; o_sum6 = b_sum6;
    end else begin
      o_q = a_q; o_rdreq = a_rdreq; o_wrreq = a_wrreq;
      o_cnt_point = a_cnt_point; o_cnt_div = a_cnt_div; o_cnt_ratio = a_cnt_ratio;
      o_cnt_measure = a_cnt_measure; o_cnt_save = a_cnt_save;
      o_div_en = a_div_en; o_ratio_en = a_ratio_en;
      o_ready = a_ready; o_ready_ratio = a_ready_ratio; o_switch = a_switch;
      o_sum1 = a_sum1; o_sum2 = a_sum2; o_sum3 = a_sum3; o_sum5 = a_sum5; o_sum6 = a_sum6;
    end
  end

  function automatic int sat12(input int v);
    return (v > 4095) ? 4095 : v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic resetModel();
    batch   = 0;
    measure = 0;
    save    = 0;
    sw      = 0;
    drain_q.delete();
    for (int i = 0; i < P; i++) acc[i] = 0;
  endtask

  // DIV then RATIO of a completed batch; optionally pokes enable during DIV.
  task automatic processBatch(input bit poke);
    int recip;
    int bw;
    int avg;
    int band;
    int s [8];
    recip = sel ? 32768 : 16384;
    bw    = sel ? 4 : 2;
    for (int n = 0; n < 8; n++) s[n] = 0;
    for (int j = 0; j < P; j++) begin
      @(negedge clock);
      checkOutput("div_en", o_div_en, 1);
      checkOutput("div_cnt", o_cnt_div, j);
      checkOutput("div_strobes", {o_rdreq, o_wrreq}, 2'b11);
      checkOutput("div_q", o_q, acc[j]);
      avg = ((acc[j] * recip) >>> 16) & 4095;
      drain_q.push_back(avg);
      band = j / bw;
      if (band inside {1, 2, 3, 5, 6}) s[band] = sat12(s[band] + avg);
      if (poke && j == 2) enable = 1'b1;
      if (poke && j == 4) enable = 1'b0;
    end
    @(negedge clock);
    checkOutput("ready_pulse", o_ready, 1);
    checkOutput("sum1", o_sum1, s[1]);
    checkOutput("sum2", o_sum2, s[2]);
    checkOutput("sum3", o_sum3, s[3]);
    checkOutput("sum5", o_sum5, s[5]);
    checkOutput("sum6", o_sum6, s[6]);
    for (int j = 0; j < P; j++) begin
      if (j > 0) @(negedge clock);
      if (j == 1) checkOutput("ready_one_cycle", o_ready, 0);
      checkOutput("ratio_en", o_ratio_en, 1);
      checkOutput("ratio_cnt", o_cnt_ratio, j);
      checkOutput("ratio_strobes", {o_rdreq, o_wrreq}, 2'b10);
      if (drain_q.size() > 0) checkOutput("ratio_q", o_q, drain_q.pop_front());
      else checkOutput("ratio_queue_empty", 1, 0);
    end
    save  = (save + 1) % 16;
    sw    = sw ^ 1;
    batch = 0;
    @(negedge clock);
    checkOutput("ready_ratio_pulse", o_ready_ratio, 1);
    checkOutput("idle_after_ratio", {o_ratio_en, o_rdreq, o_wrreq}, 3'b000);
    checkOutput("cnt_save", o_cnt_save, save);
    checkOutput("switch", o_switch, sw);
    checkOutput("fifo_empty_q", o_q, 0);
    checkOutput("measure_after_batch", o_cnt_measure, measure);
    checkOutput("sums_hold", o_sum1, s[1]);
    @(negedge clock);
    checkOutput("ready_ratio_one_cycle", o_ready_ratio, 0);
    checkOutput("no_spurious_scan", o_wrreq, 0);
  endtask

  // One scan with data = base + step*i; abort_at >= 0 resets mid-scan.
  task automatic applyStimulus(input int base, input int step, input int abort_at, input bit poke);
    int d;
    bit first;
    int meas;
    meas  = sel ? 2 : 4;
    first = (batch == 0);
    @(negedge clock);
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    for (int i = 0; i < P; i++) begin
      @(negedge clock);
      if (i == abort_at) begin
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("abort_wrreq", o_wrreq, 0);
        checkOutput("abort_rdreq", o_rdreq, 0);
        checkOutput("abort_cnt_point", o_cnt_point, 0);
        checkOutput("abort_cnt_measure", o_cnt_measure, 0);
        checkOutput("abort_q", o_q, 0);
        reset_n = 1'b1;
        resetModel();
        return;
      end
      checkOutput("scan_cnt_point", o_cnt_point, i);
      checkOutput("scan_wrreq", o_wrreq, 1);
      checkOutput("scan_rdreq", o_rdreq, first ? 0 : 1);
      if (!first) checkOutput("scan_q", o_q, acc[i]);
      d      = (base + step * i) % 4096;
      data   = 12'(d);
      acc[i] = first ? d : sat12(acc[i] + d);
    end
    measure++;
    batch++;
    if (batch == meas) begin
      processBatch(poke);
    end else begin
      @(negedge clock);
      checkOutput("idle_strobes", {o_rdreq, o_wrreq}, 2'b00);
      checkOutput("cnt_measure", o_cnt_measure, measure);
      checkOutput("cnt_point_hold", o_cnt_point, P - 1);
      checkOutput("idle_q_head", o_q, acc[0]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    sel      = 1'b0;
    reset_n  = 1'b0;
    enable   = 1'b0;
    data     = 12'd0;
    resetModel();

    // Reset held with enable toggling
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      enable = ~enable;
    end
    @(negedge clock);
    checkOutput("reset_q", o_q, 0);
    checkOutput("reset_strobes", {o_rdreq, o_wrreq}, 2'b00);
    checkOutput("reset_cnt_point", o_cnt_point, 0);
    checkOutput("reset_cnt_measure", o_cnt_measure, 0);
    checkOutput("reset_cnt_save", o_cnt_save, 0);
    checkOutput("reset_cnt_div", o_cnt_div, 0);
    checkOutput("reset_cnt_ratio", o_cnt_ratio, 0);
    checkOutput("reset_flags", {o_div_en, o_ratio_en, o_ready, o_ready_ratio, o_switch}, 5'b0);
    checkOutput("reset_sums", {o_sum1, o_sum2, o_sum3, o_sum5, o_sum6}, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checkOutput("post_reset_wrreq", o_wrreq, 0);
      checkOutput("post_reset_cnt_point", o_cnt_point, 0);
    end

    // Batch 1: constant data, ignored trigger during DIV
    for (int k = 0; k < 4; k++) applyStimulus(10, 0, -1, 1'b1);

    // Batch 2: varying data per scan and per point
    for (int k = 0; k < 4; k++) applyStimulus(100 + 50 * k, 37, -1, 1'b0);

    // Reset mid-scan, then a fresh first scan
    applyStimulus(5, 1, 7, 1'b0);
    applyStimulus(20, 3, -1, 1'b0);

    // Saturation instance
    enable = 1'b1;
    @(negedge clock);
    sel     = 1'b1;
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    resetModel();
    for (int k = 0; k < 2; k++) applyStimulus(4000, 0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
